// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcode encodings, the
// opcode field position and the sequencer state enum.
package cpu_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;

    localparam logic [3:0] OP_ADD   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'h9;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_CLEAR = 4'hC;
    localparam logic [3:0] OP_SKIP  = 4'hD;
    localparam logic [3:0] OP_JUMP  = 4'hE;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } state_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] ir);
        return ir[OPC_HI:OPC_LO];
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_JUMP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_mem_req_hold.sv
// Request/ready hold for a memory port: the request stays up for as long as the
// owning phase is active and is forced low the instant reset is asserted.
module mem_req_hold (
    input  logic rst_n_i,
    input  logic active_i,
    input  logic ready_i,
    output logic req_o,
    output logic done_o
);

    // Handshake: a transfer completes on a cycle where req_o=1 and ready_i=1;
    // the requester keeps address/data stable until then.
    assign req_o  = rst_n_i & active_i;
    assign done_o = req_o & ready_i;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer: owns PC and IR, walks FETCH/DECODE/EXEC/MEM/WB and
// gates register-file and PC writes to one cycle per instruction.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W        = 8,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter int                DECODE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [15:0]       instruction,
    input  logic              cu_reg_write_enable,
    input  logic              cu_pc_write_enable,
    input  logic              cu_jump_enable,
    input  logic              cu_halt,
    output logic              alu_en,
    input  logic              alu_zero,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal_op,
    output logic [2:0]        dbg_state
);

    localparam int             DCW     = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;
    localparam logic [DCW-1:0] DC_LAST = DCW'(DECODE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DCW-1:0]    dcnt_q, dcnt_d;
    logic              reg_we_q, reg_we_d;
    logic              pc_we_q, pc_we_d;
    logic              jump_q, jump_d;
    logic              skip_q, skip_d;
    logic [3:0]        op;
    logic              fetch_st, mem_st, imem_done, dmem_done;

    assign op       = opcode_of(ir_q);
    assign fetch_st = (state_q == FETCH);
    assign mem_st   = (state_q == MEM);

    mem_req_hold u_imem_hold (
        .rst_n_i (reset),
        .active_i(fetch_st),
        .ready_i (imem_ready),
        .req_o   (imem_req),
        .done_o  (imem_done)
    );

    mem_req_hold u_dmem_hold (
        .rst_n_i (reset),
        .active_i(mem_st),
        .ready_i (dmem_ready),
        .req_o   (dmem_req),
        .done_o  (dmem_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            dcnt_q   <= '0;
            reg_we_q <= 1'b0;
            pc_we_q  <= 1'b0;
            jump_q   <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            dcnt_q   <= dcnt_d;
            reg_we_q <= reg_we_d;
            pc_we_q  <= pc_we_d;
            jump_q   <= jump_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        dcnt_d     = dcnt_q;
        reg_we_d   = reg_we_q;
        pc_we_d    = pc_we_q;
        jump_d     = jump_q;
        skip_d     = skip_q;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_done) begin
                    ir_d    = imem_rdata;
                    dcnt_d  = DC_LAST;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - 1'b1;
                end else begin
                    // control_unit has had DECODE_CYCLES to settle on the held IR
                    reg_we_d = cu_reg_write_enable;
                    pc_we_d  = cu_pc_write_enable;
                    jump_d   = cu_jump_enable;
                    skip_d   = 1'b0;
                    if (cu_halt) begin
                        state_d = HALTED;
                    end else if (!is_legal(op)) begin
                        illegal_op = 1'b1;
                        state_d    = WB;
                    end else begin
                        case (op)
                            OP_ADD, OP_CLEAR, OP_SKIP: state_d = EXEC;
                            OP_LOAD, OP_STORE:         state_d = MEM;
                            default:                   state_d = WB;
                        endcase
                    end
                end
            end
            EXEC: begin
                alu_en = 1'b1;
                if (op == OP_SKIP) skip_d = alu_zero;
                state_d = WB;
            end
            MEM: begin
                if (dmem_done) state_d = WB;
            end
            WB: begin
                rf_we = reg_we_q && ((op == OP_ADD) || (op == OP_CLEAR) || (op == OP_LOAD));
                if (jump_q) begin
                    pc_d = ir_q[ADDR_W-1:0];
                end else if (pc_we_q) begin
                    pc_d = pc_q + ADDR_W'(1) + ADDR_W'(skip_q);
                end
                state_d = FETCH;
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    assign imem_addr   = pc_q;
    assign instruction = ir_q;
    assign dmem_we     = dmem_req & (op == OP_STORE);
    assign dmem_addr   = ir_q[ADDR_W-1:0];
    assign pc          = pc_q;
    assign halted      = (state_q == HALTED);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle outputs, compared on every falling edge.
module tb_cpu_sequencer;

    localparam int          AW = 8;
    localparam int          DC = 1;
    localparam logic [7:0]  RST_PC = 8'h00;
    localparam int          VW = 47;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] instruction;
    logic        cu_reg_write_enable, cu_pc_write_enable, cu_jump_enable, cu_halt;
    logic        alu_en, alu_zero;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic        dmem_ready;
    logic        rf_we;
    logic [7:0]  pc;
    logic        halted, illegal_op;
    logic [2:0]  dbg_state;

    cpu_sequencer #(.ADDR_W(AW), .RESET_PC(RST_PC), .DECODE_CYCLES(DC)) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .imem_ready         (imem_ready),
        .instruction        (instruction),
        .cu_reg_write_enable(cu_reg_write_enable),
        .cu_pc_write_enable (cu_pc_write_enable),
        .cu_jump_enable     (cu_jump_enable),
        .cu_halt            (cu_halt),
        .alu_en             (alu_en),
        .alu_zero           (alu_zero),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_ready         (dmem_ready),
        .rf_we              (rf_we),
        .pc                 (pc),
        .halted             (halted),
        .illegal_op         (illegal_op),
        .dbg_state          (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state and scoreboard
    logic [7:0]    m_pc;
    logic [15:0]   m_ir;
    bit            m_halted;
    logic [VW-1:0] exp_q[$];
    int            n_vec;
    int            n_err;

    function automatic logic [VW-1:0] mk(input bit ireq, input bit alu, input bit dreq,
                                         input bit dwe, input bit rfwe, input bit ill);
        return {ireq, m_pc, m_ir, alu, dreq, dwe, m_ir[7:0], rfwe, m_pc, m_halted, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e;
            logic [VW-1:0] a;
            e = exp_q.pop_front();
            a = {imem_req, imem_addr, instruction, alu_en, dmem_req, dmem_we, dmem_addr,
                 rf_we, pc, halted, illegal_op};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL cycle_vec t=%0t: got %h, expected %h", $time, a, e);
            end
        end
    end

    // driver tasks
    task automatic step(input logic [VW-1:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        imem_rdata = 16'($urandom);
    endtask

    task automatic run_instr(input logic [15:0] ins, input bit rwe, input bit pwe,
                             input bit jmp, input bit hlt, input bit az,
                             input int iw, input int dw);
        logic [3:0] op;
        bit         ill, is_exec, is_mem, skip;
        op      = ins[15:12];
        ill     = (op < 4'h8) || (op == 4'hF);
        is_exec = (op == 4'h8) || (op == 4'hC) || (op == 4'hD);
        is_mem  = (op == 4'hA) || (op == 4'hB);
        cu_reg_write_enable = rwe;
        cu_pc_write_enable  = pwe;
        cu_jump_enable      = jmp;
        cu_halt             = hlt;
        alu_zero            = az;
        for (int i = 0; i <= iw; i++) begin
            dmem_ready = 1'($urandom);
            imem_ready = (i == iw);
            imem_rdata = (i == iw) ? ins : 16'($urandom);
            step(mk(1, 0, 0, 0, 0, 0));
        end
        m_ir = ins;
        for (int i = 0; i < DC; i++) begin
            noise();
            step(mk(0, 0, 0, 0, 0, (i == DC - 1) && !hlt && ill));
        end
        if (hlt) begin
            m_halted = 1'b1;
            return;
        end
        skip = 1'b0;
        if (!ill && is_exec) begin
            noise();
            step(mk(0, 1, 0, 0, 0, 0));
            skip = (op == 4'hD) && az;
        end else if (!ill && is_mem) begin
            for (int i = 0; i <= dw; i++) begin
                imem_ready = 1'($urandom);
                dmem_ready = (i == dw);
                step(mk(0, 0, 1, op == 4'hB, 0, 0));
            end
        end
        noise();
        step(mk(0, 0, 0, 0, rwe && ((op == 4'h8) || (op == 4'hC) || (op == 4'hA)), 0));
        if (jmp)      m_pc = ins[7:0];
        else if (pwe) m_pc = m_pc + 8'd1 + 8'(skip);
    endtask

    task automatic halt_idle(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ready = 1'b1;
            dmem_ready = 1'($urandom);
            step(mk(0, 0, 0, 0, 0, 0));
        end
    endtask

    // Entered at posedge+1; reset falls mid-cycle and must drop requests at once.
    task automatic rst_pulse();
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_imem_req_drop", 32'(imem_req), 32'd0);
        check("rst_dmem_req_drop", 32'(dmem_req), 32'd0);
        check("rst_halted_clear", 32'(halted), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        m_pc     = RST_PC;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_refetch_req", 32'(imem_req), 32'd1);
        check("rst_ir", 32'(instruction), 32'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        imem_rdata = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        cu_reg_write_enable = 1'b0;
        cu_pc_write_enable  = 1'b0;
        cu_jump_enable      = 1'b0;
        cu_halt             = 1'b0;
        alu_zero            = 1'b0;
        m_pc     = RST_PC;
        m_ir     = 16'h0000;
        m_halted = 1'b0;
        #7;
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_pc", 32'(pc), 32'h00);
        check("reset_strobes", 32'({alu_en, rf_we, dmem_req, illegal_op, halted}), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        run_instr(16'h8801, 1, 1, 0, 0, 0, 0, 0);
        check("add_pc", 32'(pc), 32'h01);
        run_instr(16'hA803, 1, 1, 0, 0, 0, 0, 3);
        check("load_pc", 32'(pc), 32'h02);
        run_instr(16'hB804, 1, 1, 0, 0, 0, 1, 0);
        check("store_pc", 32'(pc), 32'h03);
        run_instr(16'h1234, 1, 1, 0, 0, 0, 0, 0);
        check("illegal_pc", 32'(pc), 32'h04);
        run_instr(16'hE0FF, 0, 0, 1, 0, 0, 0, 0);
        check("jump_ff_pc", 32'(pc), 32'hFF);
        run_instr(16'hD806, 0, 1, 0, 0, 1, 0, 0);
        check("skip_taken_wrap_pc", 32'(pc), 32'h01);
        run_instr(16'hE0FF, 0, 0, 1, 0, 0, 0, 0);
        run_instr(16'hD806, 0, 1, 0, 0, 0, 0, 0);
        check("skip_not_taken_wrap_pc", 32'(pc), 32'h00);
        run_instr(16'hE807, 0, 0, 1, 0, 0, 0, 0);
        check("jump_07_pc", 32'(pc), 32'h07);
        run_instr(16'h9802, 0, 0, 0, 1, 0, 0, 0);
        halt_idle(20);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_no_req", 32'(imem_req), 32'd0);
        rst_pulse();

        // reset while a fetch is stalled on imem_ready=0
        imem_ready = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0));
        rst_pulse();

        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            bit rwe, pwe, jmp, hlt, az;
            int iw, dw;
            ins = 16'($urandom);
            rwe = 1'($urandom);
            pwe = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 5) == 0);
            hlt = ($urandom_range(0, 24) == 0);
            az  = 1'($urandom);
            iw  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            dw  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_instr(ins, rwe, pwe, jmp, hlt, az, iw, dw);
            if (hlt) begin
                halt_idle(int'($urandom_range(2, 6)));
                rst_pulse();
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle sequencer that owns the program counter and instruction register and drives the control_unit.
- Fetches 16-bit instructions over an instruction-memory handshake and holds each one stable for control_unit.
- Samples control_unit's decoded enables, then steps the datapath through EXEC, MEM and WB.
- Gates register-file writes and PC updates to exactly one cycle per instruction, and parks the core on HALT.

Parameters:
ADDR_W, 8, width of PC and of the imem/dmem word addresses (must be <= 12)
RESET_PC, 0, PC value loaded on reset
DECODE_CYCLES, 1, cycles the IR is held in DECODE before control_unit outputs are sampled (>= 1)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_rdata  in  16  fetched instruction, valid when imem_ready=1
imem_ready  in  1  fetch completes on the cycle imem_req=1 and imem_ready=1
instruction  out  16  IR contents presented to control_unit
cu_reg_write_enable  in  1  from control_unit
cu_pc_write_enable  in  1  from control_unit
cu_jump_enable  in  1  from control_unit
cu_halt  in  1  from control_unit
alu_en  out  1  one-cycle ALU strobe in EXEC
alu_zero  in  1  ALU zero flag, sampled in EXEC
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  ADDR_W  IR[ADDR_W-1:0]
dmem_ready  in  1  data access completes on the cycle dmem_req=1 and dmem_ready=1
rf_we  out  1  one-cycle register-file write strobe
pc  out  ADDR_W  current PC
halted  out  1  core stopped
illegal_op  out  1  one-cycle pulse when IR holds an undefined opcode

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC, IR=0.
  - All request, strobe and flag outputs are 0.
  - A reset asserted mid-transaction drops imem_req and dmem_req immediately.
- Opcode is IR[15:12]: 8=ADD, 9=HALT, A=LOAD, B=STORE, C=CLEAR, D=SKIP, E=JUMP. All other opcodes are illegal.
- FETCH:
  - imem_req=1 and imem_addr=pc; both are held until imem_ready.
  - On ready, IR<=imem_rdata and state goes to DECODE.
  - Zero-wait memory means a one-cycle FETCH.
- DECODE:
  - Lasts DECODE_CYCLES cycles, counted by a down-counter.
  - On the last cycle the cu_* inputs are registered into latched controls, then the next state is selected in this priority:
    - cu_halt=1: go to HALTED.
    - Illegal opcode: pulse illegal_op and go to WB; it is treated as a NOP.
    - ADD, CLEAR, SKIP: go to EXEC.
    - LOAD, STORE: go to MEM.
    - JUMP: go to WB.
- EXEC: one cycle. alu_en=1. For SKIP, alu_zero is latched as skip_taken. Next state is WB.
- MEM:
  - dmem_req=1, dmem_we=(opcode==STORE), dmem_addr=IR[ADDR_W-1:0]; all are held until dmem_ready.
  - On ready, state goes to WB.
- WB: one cycle, then FETCH.
  - rf_we = latched reg_write_enable AND opcode in {ADD, CLEAR, LOAD}. rf_we is never asserted for STORE, SKIP, JUMP or illegal opcodes.
  - PC update, in priority order:
    - latched jump_enable: pc<=IR[ADDR_W-1:0].
    - else latched pc_write_enable: pc<=pc+1+skip_taken.
    - else pc holds, so the same instruction is refetched.
  - PC arithmetic is modulo 2^ADDR_W; SKIP taken at pc=2^ADDR_W-1 gives pc=1.
- HALTED: terminal state. halted=1; no requests and no strobes. Only reset exits it; imem_ready and dmem_ready are ignored.
- Latency with zero-wait memories: 4 cycles per ADD, CLEAR, SKIP, LOAD or STORE; 3 cycles per JUMP or illegal opcode.
- IR and instruction change only on fetch completion.
- rf_we, alu_en and illegal_op are never high for more than one cycle per instruction.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_JUMP;
  - a state enum {FETCH, DECODE, EXEC, MEM, WB, HALTED};
  - the opcode field position [15:12].
- The memory-handshake hold logic, used for both imem and dmem, is the one natural sub-module: mem_req_hold (req held until ready, dropped on reset).

Test Plan:
- Reset release, control_unit giving ADD 0x8801 with reg_write=1 and pc_write=1, zero-wait imem -> rf_we is high in cycle 4 only; alu_en is high in cycle 3; pc goes 0->1.
- LOAD 0xA803 with dmem_ready delayed 3 cycles -> dmem_req=1 and dmem_we=0 with dmem_addr=0x03 for 4 cycles; rf_we pulses once after ready.
- STORE 0xB804 -> dmem_we=1 and dmem_addr=0x04; rf_we stays 0; pc increments.
- SKIP 0xD806 at pc=0xFF with alu_zero=1 -> pc=0x01; with alu_zero=0 -> pc=0x00.
- JUMP 0xE807 with cu_jump_enable=1 -> pc=0x07 in 3 cycles; then HALT 0x9802 with cu_halt=1 -> halted=1 and imem_req stays 0 for 20 cycles.
- Reset pulled low while imem_req is waiting on imem_ready=0 -> imem_req drops within the same cycle; after release, pc=RESET_PC and a fetch is reissued.
